// File: rtl/ets_sweep_buffer.sv
// ets_sweep_buffer: collects one ETS sweep of N_POINTS results and replays it on an AXI4-Stream master
//   clk, reset_n                 clock, async active-low reset
//   start, abort                 sweep start pulse (IDLE only), synchronous abort to IDLE
//   busy, done, point_cnt        status: not IDLE, 1-cycle end pulse, results stored this sweep
//   ets_en, ets_data/valid/ready ETS core enable and result handshake
//   m_axis_*                     stream master, tlast on the final point
module ets_sweep_buffer #(
    parameter int DATA_W   = 32,
    parameter int N_POINTS = 448,
    parameter int ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] point_cnt,
    output logic              ets_en,
    input  logic [DATA_W-1:0] ets_data,
    input  logic              ets_valid,
    output logic              ets_ready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);
    typedef enum logic [2:0] {S_IDLE, S_ACQ, S_DRAIN, S_STREAM, S_FIN} state_t;
    localparam int AI = (N_POINTS > 2) ? $clog2(N_POINTS) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_POINTS - 1);
    localparam logic [ADDR_W:0]   NP   = (ADDR_W+1)'(N_POINTS);
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_buf [N_POINTS];
    logic [ADDR_W-1:0] r_point_cnt, r_beat;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [DATA_W-1:0] r_mem_q, r_skid, r_out;
    logic              r_mem_v, r_skid_v, r_out_v, r_ets_en;
    logic              w_acc, w_last_acc, w_pop, w_last_pop, w_issue, w_take;
    logic [1:0]        w_occ;
    assign ets_ready     = r_state == S_ACQ;
    assign w_acc         = ets_valid && ets_ready && !abort;
    assign w_last_acc    = w_acc && r_point_cnt == LAST;
    assign w_pop         = r_out_v && m_axis_tready;
    assign w_last_pop    = w_pop && r_beat == LAST;
    assign w_take        = !r_out_v || w_pop;
    // Beats in flight: read stage + output + skid. Keeping this at most 2 means
    // a word arriving from the read stage always has a free slot to land in.
    assign w_occ         = 2'(r_out_v) + 2'(r_skid_v) + 2'(r_mem_v);
    assign w_issue       = r_state == S_STREAM && !abort && r_rd_ptr < NP &&
                           (w_occ < 2'd2 || (w_occ == 2'd2 && w_pop));
    assign busy          = r_state != S_IDLE;
    assign done          = r_state == S_FIN;
    assign point_cnt     = r_point_cnt;
    assign ets_en        = r_ets_en;
    assign m_axis_tdata  = r_out;
    assign m_axis_tvalid = r_out_v;
    assign m_axis_tlast  = r_out_v && r_beat == LAST;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = start ? S_ACQ : S_IDLE;
            S_ACQ:    w_next = w_last_acc ? S_DRAIN : S_ACQ;
            S_DRAIN:  w_next = S_STREAM;
            S_STREAM: w_next = w_last_pop ? S_FIN : S_STREAM;
            default:  w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ets_en    <= 1'b0;
            r_point_cnt <= '0;
            r_rd_ptr    <= '0;
            r_beat      <= '0;
            r_mem_v     <= 1'b0;
            r_skid_v    <= 1'b0;
            r_out_v     <= 1'b0;
            r_skid      <= '0;
            r_out       <= '0;
        end else begin
            r_ets_en    <= abort ? 1'b0 : (r_state == S_IDLE && start) ? 1'b1 : w_last_acc ? 1'b0 : r_ets_en;
            r_point_cnt <= (r_state == S_IDLE && start && !abort) ? '0 :
                           w_acc ? r_point_cnt + ADDR_W'(1) : r_point_cnt;
            r_rd_ptr    <= r_state == S_DRAIN ? '0 : w_issue ? r_rd_ptr + (ADDR_W+1)'(1) : r_rd_ptr;
            r_beat      <= r_state == S_DRAIN ? '0 : w_pop ? r_beat + ADDR_W'(1) : r_beat;
            r_mem_v     <= w_issue;
            if (r_mem_v) r_skid <= r_mem_q;
            if (r_state != S_STREAM || abort) begin
                r_out_v  <= 1'b0;
                r_skid_v <= 1'b0;
            end else if (w_take) begin
                r_out    <= r_skid_v ? r_skid : r_mem_q;
                r_out_v  <= r_skid_v || r_mem_v;
                r_skid_v <= r_skid_v && r_mem_v;
            end else if (r_mem_v) begin
                r_skid_v <= 1'b1;
            end
        end
    end
    // Plain synchronous RAM: no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (w_acc) r_buf[r_point_cnt[AI-1:0]] <= ets_data;
        r_mem_q <= r_buf[r_rd_ptr[AI-1:0]];
    end
endmodule

// File: tb/tb_ets_sweep_buffer.sv
// tb_ets_sweep_buffer: directed self-checking bench for ets_sweep_buffer with a 4-point sweep
module tb_ets_sweep_buffer;
    localparam int DW = 32;
    localparam int NP = 4;
    localparam int AW = 3;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ets_valid = 1'b0;
    logic [DW-1:0] ets_data = '0;
    logic          m_axis_tready = 1'b0;
    logic          busy, done, ets_en, ets_ready, m_axis_tvalid, m_axis_tlast;
    logic [AW-1:0] point_cnt;
    logic [DW-1:0] m_axis_tdata;
    logic [31:0]   exp_d [NP];
    int            checks = 0;
    int            errors = 0;

    ets_sweep_buffer #(.DATA_W(DW), .N_POINTS(NP), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .point_cnt(point_cnt), .ets_en(ets_en),
        .ets_data(ets_data), .ets_valid(ets_valid), .ets_ready(ets_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_acq();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("en_after_start", ets_en, 1'b1);
        chk1("busy_acq", busy, 1'b1);
        chk1("ready_acq", ets_ready, 1'b1);
        chk32("pcnt_cleared", 32'(point_cnt), 32'd0);
        for (int i = 0; i < NP; i++) begin
            ets_valid = 1'b1;
            ets_data  = exp_d[i];
            tick();
            if (i < NP - 1) chk1("en_hold", ets_en, 1'b1);
        end
        ets_valid = 1'b0;
        chk1("en_fall", ets_en, 1'b0);
        chk32("pcnt_full", 32'(point_cnt), 32'(NP));
        chk1("ready_drain", ets_ready, 1'b0);
    endtask

    task automatic wait_first();
        tick();
        chk1("tvalid_entry", m_axis_tvalid, 1'b0);
        tick();
        chk1("tvalid_entry1", m_axis_tvalid, 1'b0);
        tick();
        chk1("tvalid_first", m_axis_tvalid, 1'b1);
        chk32("tdata_first", m_axis_tdata, exp_d[0]);
    endtask

    task automatic collect(input logic [3:0] pat, input logic chk_thru);
        int k = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [31:0] hold_d = '0;
        logic hold_l = 1'b0;
        while (k < NP && cyc < 40) begin
            m_axis_tready = pat[3 - (cyc % 4)];
            chk1("done_early", done, 1'b0);
            if (m_axis_tvalid) begin
                if (stalled) begin
                    chk32("stall_data", m_axis_tdata, hold_d);
                    chk1("stall_last", m_axis_tlast, hold_l);
                end
                if (m_axis_tready) begin
                    chk32("beat_data", m_axis_tdata, exp_d[k]);
                    chk1("beat_last", m_axis_tlast, k == NP - 1);
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_d  = m_axis_tdata;
                    hold_l  = m_axis_tlast;
                end
            end else if (stalled) begin
                chk1("valid_drop", m_axis_tvalid, 1'b1);
                stalled = 1'b0;
            end
            tick();
            cyc++;
        end
        m_axis_tready = 1'b0;
        chk32("beat_count", k, NP);
        if (chk_thru) chk32("throughput_cycles", cyc, NP);
        chk1("done_pulse", done, 1'b1);
        chk1("busy_fin", busy, 1'b1);
        chk1("tvalid_fin", m_axis_tvalid, 1'b0);
        tick();
        chk1("done_low", done, 1'b0);
        chk1("busy_idle", busy, 1'b0);
        chk32("pcnt_held", 32'(point_cnt), 32'(NP));
    endtask

    initial begin
        // Reset state
        tick();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_en", ets_en, 1'b0);
        chk1("rst_ready", ets_ready, 1'b0);
        chk1("rst_tvalid", m_axis_tvalid, 1'b0);
        chk1("rst_tlast", m_axis_tlast, 1'b0);
        chk32("rst_tdata", m_axis_tdata, 32'd0);
        chk32("rst_pcnt", 32'(point_cnt), 32'd0);
        reset_n = 1'b1;
        tick();
        // ets_valid while IDLE is neither accepted nor counted
        ets_valid = 1'b1;
        ets_data  = 32'hDEAD;
        #1;
        chk1("idle_ready", ets_ready, 1'b0);
        tick();
        ets_valid = 1'b0;
        chk32("idle_pcnt", 32'(point_cnt), 32'd0);
        chk1("idle_busy", busy, 1'b0);

        // Basic sweep, tready always high
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        m_axis_tready = 1'b1;
        run_acq();
        wait_first();
        collect(4'b1111, 1'b1);

        // Same sweep with tready toggling 1-0-0-1
        run_acq();
        wait_first();
        collect(4'b1001, 1'b0);

        // ets_valid held high continuously: only 4 results are taken
        exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        start = 1'b1;
        tick();
        start = 1'b0;
        ets_valid = 1'b1;
        for (int i = 0; i < NP; i++) begin
            ets_data = 32'hA0 + 32'(i);
            tick();
        end
        ets_data = 32'hEE;
        chk1("held_en_fall", ets_en, 1'b0);
        chk32("held_pcnt", 32'(point_cnt), 32'd4);
        m_axis_tready = 1'b1;
        wait_first();
        ets_valid = 1'b0;
        chk32("held_pcnt_after", 32'(point_cnt), 32'd4);
        collect(4'b1111, 1'b1);

        // Abort in ACQ after two accepts, with a result offered on the abort cycle
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        start = 1'b1;
        tick();
        start = 1'b0;
        ets_valid = 1'b1;
        ets_data  = 32'h55;
        tick();
        ets_data  = 32'h66;
        tick();
        chk32("abort_pcnt_pre", 32'(point_cnt), 32'd2);
        ets_data = 32'h77;
        abort    = 1'b1;
        tick();
        abort     = 1'b0;
        ets_valid = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_en", ets_en, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_tvalid", m_axis_tvalid, 1'b0);
        chk32("abort_pcnt", 32'(point_cnt), 32'd2);
        tick();
        chk1("abort_done_after", done, 1'b0);
        // Clean sweep after abort
        m_axis_tready = 1'b1;
        run_acq();
        wait_first();
        collect(4'b1111, 1'b1);

        // start pulsed during STREAM is ignored
        run_acq();
        wait_first();
        m_axis_tready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("stream_start_busy", busy, 1'b1);
        chk1("stream_start_en", ets_en, 1'b0);
        chk1("stream_start_tvalid", m_axis_tvalid, 1'b1);
        chk32("stream_start_tdata", m_axis_tdata, 32'h11);
        collect(4'b1111, 1'b1);

        // Async reset mid-STREAM
        m_axis_tready = 1'b1;
        run_acq();
        wait_first();
        m_axis_tready = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk1("arst_tvalid", m_axis_tvalid, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_en", ets_en, 1'b0);
        chk32("arst_pcnt", 32'(point_cnt), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk1("post_rst_busy", busy, 1'b0);
        chk1("post_rst_ready", ets_ready, 1'b0);
        chk1("post_rst_tvalid", m_axis_tvalid, 1'b0);
        m_axis_tready = 1'b1;
        run_acq();
        wait_first();
        collect(4'b1111, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
